// File: rtl/base_arb_pkg.sv
// Shared types and helpers for the arbiter output stage.
package base_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } arb_state_e;

  localparam int MAXW = 32;

  // Index of the lowest set bit; zero when no bit is set.
  function automatic int lowest_idx(input logic [MAXW-1:0] v);
    lowest_idx = 0;
    for (int k = MAXW - 1; k >= 0; k--) begin
      if (v[k]) lowest_idx = k;
    end
  endfunction

  function automatic logic multi_set(input logic [MAXW-1:0] v);
    return (v & (v - MAXW'(1))) != '0;
  endfunction

endpackage

// File: rtl/base_skid.sv
// Two-entry registered skid: 1-cycle latency, full rate; i_r drops only when both entries hold data.
module base_skid
  import base_arb_pkg::*;
#(
  parameter int width = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_v,
  output logic             i_r,
  input  logic [width-1:0] i_d,
  output logic             o_v,
  input  logic             o_r,
  output logic [width-1:0] o_d
);

  logic             r_m_v;
  logic [width-1:0] r_m_d;
  logic             r_s_v;
  logic [width-1:0] r_s_d;
  logic             w_push;
  logic             w_pop;

  assign i_r    = ~r_s_v;
  assign o_v    = r_m_v;
  assign o_d    = r_m_d;
  assign w_push = i_v & ~r_s_v;
  assign w_pop  = r_m_v & o_r;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_m_v <= 1'b0;
      r_m_d <= '0;
      r_s_v <= 1'b0;
      r_s_d <= '0;
    end else if (w_pop) begin
      // Skid has priority on a pop; a push cannot coincide with a full skid.
      if (r_s_v) begin
        r_m_d <= r_s_d;
        r_s_v <= 1'b0;
      end else if (w_push) begin
        r_m_d <= i_d;
      end else begin
        r_m_v <= 1'b0;
      end
    end else if (!r_m_v) begin
      if (w_push) begin
        r_m_v <= 1'b1;
        r_m_d <= i_d;
      end
    end else if (w_push) begin
      r_s_v <= 1'b1;
      r_s_d <= i_d;
    end
  end

endmodule

// File: rtl/base_arbostage.sv
// Registered stage after the priority arbiter: muxes the granted way, holds a packet lock mask.
// Latency 1 cycle; s_r comes only from flops and drops when the internal skid is full.
module base_arbostage
  import base_arb_pkg::*;
#(
  parameter int ways  = 2,
  parameter int width = 8,
  localparam int encw = (ways > 1) ? $clog2(ways) : 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [ways-1:0]       s_v,
  output logic                  s_r,
  input  logic [ways*width-1:0] s_d,
  input  logic [ways-1:0]       s_e,
  output logic [ways-1:0]       lk,
  output logic                  o_v,
  input  logic                  o_r,
  output logic [width-1:0]      o_d,
  output logic                  o_e,
  output logic [encw-1:0]       o_s,
  output logic                  err
);

  localparam int BW = width + 1 + encw;

  logic [MAXW-1:0]  w_req;
  logic [encw-1:0]  w_sel;
  logic [width-1:0] w_dat;
  logic             w_eop;
  logic             w_acc;
  logic             w_skid_ir;
  logic [BW-1:0]    w_out;
  logic             r_rdy;
  logic             r_err;
  logic             w_viol;
  arb_state_e       r_state;
  arb_state_e       w_state_nxt;
  logic [encw-1:0]  r_lk_way;
  logic [encw-1:0]  w_lk_way_nxt;

  // Way k lives on the MSB side of every per-way vector; w_req puts way k at bit k.
  always_comb begin
    w_req = '0;
    for (int k = 0; k < ways; k++) w_req[k] = s_v[ways-1-k];
  end

  assign w_sel = encw'(lowest_idx(w_req));

  always_comb begin
    w_dat = '0;
    w_eop = 1'b0;
    for (int k = 0; k < ways; k++) begin
      if (w_sel == encw'(k)) begin
        w_dat = s_d[(ways-1-k)*width +: width];
        w_eop = s_e[ways-1-k];
      end
    end
  end

  assign s_r   = r_rdy & w_skid_ir;
  assign w_acc = s_r & (|s_v);

  base_skid #(.width(BW)) u_skid (
    .clk     (clk),
    .reset_n (reset_n),
    .i_v     (r_rdy & (|s_v)),
    .i_r     (w_skid_ir),
    .i_d     ({w_dat, w_eop, w_sel}),
    .o_v     (o_v),
    .o_r     (o_r),
    .o_d     (w_out)
  );

  assign {o_d, o_e, o_s} = w_out;

  always_comb begin
    w_state_nxt  = r_state;
    w_lk_way_nxt = r_lk_way;
    w_viol       = 1'b0;
    case (r_state)
      IDLE: if (w_acc && !w_eop) begin
        w_state_nxt  = LOCK;
        w_lk_way_nxt = w_sel;
      end
      LOCK: if (w_acc) begin
        if (w_sel != r_lk_way) w_viol = 1'b1;
        else if (w_eop)        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= IDLE;
      r_lk_way <= '0;
      r_rdy    <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_lk_way <= w_lk_way_nxt;
      r_rdy    <= 1'b1;
      if (w_acc && (multi_set(w_req) || w_viol)) r_err <= 1'b1;
    end
  end

  always_comb begin
    lk = '1;
    if (r_state == LOCK) begin
      lk = '0;
      for (int k = 0; k < ways; k++) begin
        if (r_lk_way == encw'(k)) lk[ways-1-k] = 1'b1;
      end
    end
  end

  assign err = r_err;

endmodule

// File: tb/tb_base_arbostage.sv
// Bench for base_arbostage: queue-based reference model compared every cycle plus directed literal checks.
module tb_base_arbostage;

  localparam int W  = 2;
  localparam int DW = 8;

  logic            clk;
  logic            reset_n;
  logic [W-1:0]    s_v;
  logic            s_r;
  logic [W*DW-1:0] s_d;
  logic [W-1:0]    s_e;
  logic [W-1:0]    lk;
  logic            o_v;
  logic            o_r;
  logic [DW-1:0]   o_d;
  logic            o_e;
  logic [0:0]      o_s;
  logic            err;

  base_arbostage #(.ways(W), .width(DW)) dut (
    .clk(clk), .reset_n(reset_n), .s_v(s_v), .s_r(s_r), .s_d(s_d), .s_e(s_e),
    .lk(lk), .o_v(o_v), .o_r(o_r), .o_d(o_d), .o_e(o_e), .o_s(o_s), .err(err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: a FIFO of at most two beats, a ready flag, the locked way and a sticky error.
  typedef struct {
    logic [DW-1:0] d;
    logic          e;
    int            s;
  } beat_t;

  beat_t q[$];
  bit    m_rdy  = 1'b0;
  int    m_lock = -1;
  bit    m_err  = 1'b0;

  always @(negedge clk) begin
    bit    exp_sr;
    bit    acc;
    bit    pop;
    int    sel;
    int    nset;
    beat_t b;
    if (!reset_n) begin
      q.delete();
      m_rdy  = 1'b0;
      m_lock = -1;
      m_err  = 1'b0;
    end
    exp_sr = m_rdy && (q.size() < 2);
    chk("s_r", 32'(s_r), 32'(exp_sr));
    chk("o_v", 32'(o_v), 32'(q.size() > 0));
    chk("lk", 32'(lk), (m_lock < 0) ? 32'h3 : 32'(1 << (W - 1 - m_lock)));
    chk("err", 32'(err), 32'(m_err));
    if (q.size() > 0) begin
      chk("o_d", 32'(o_d), 32'(q[0].d));
      chk("o_e", 32'(o_e), 32'(q[0].e));
      chk("o_s", 32'(o_s), 32'(q[0].s));
    end
    if (reset_n) begin
      sel  = -1;
      nset = 0;
      for (int k = 0; k < W; k++) begin
        if (s_v[W-1-k]) begin
          nset++;
          if (sel < 0) sel = k;
        end
      end
      acc = exp_sr && (nset > 0);
      pop = (q.size() > 0) && o_r;
      if (pop) void'(q.pop_front());
      if (acc) begin
        b.d = s_d[(W-1-sel)*DW +: DW];
        b.e = s_e[W-1-sel];
        b.s = sel;
        q.push_back(b);
        if (nset > 1) m_err = 1'b1;
        if (m_lock < 0) begin
          if (!b.e) m_lock = sel;
        end else if (sel != m_lock) begin
          m_err = 1'b1;
        end else if (b.e) begin
          m_lock = -1;
        end
      end
      m_rdy = 1'b1;
    end
  end

  task automatic pulse_reset();
    @(posedge clk); #2 reset_n = 1'b0;
    @(posedge clk);
    @(posedge clk); #2 reset_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int r;
    int way;
    reset_n = 1'b0;
    s_v = 2'b10;
    s_d = {8'hA5, 8'h3C};
    s_e = 2'b11;
    o_r = 1'b1;

    // Reset release with a grant already held on way 0.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_s_r", 32'(s_r), 32'h0);
    chk("rst_lk", 32'(lk), 32'h3);
    chk("rst_o_v", 32'(o_v), 32'h0);
    @(posedge clk); #2 reset_n = 1'b1;
    @(negedge clk);
    chk("rel_s_r_first", 32'(s_r), 32'h0);
    @(negedge clk);
    chk("rel_s_r_second", 32'(s_r), 32'h1);
    @(posedge clk); #1 s_v = 2'b00;
    @(negedge clk);
    chk("first_o_v", 32'(o_v), 32'h1);
    chk("first_o_s", 32'(o_s), 32'h0);
    chk("first_o_d", 32'(o_d), 32'hA5);

    // Streaming single-beat packets, alternating ways.
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      s_v = (i % 2 == 0) ? 2'b10 : 2'b01;
      s_d = 16'($urandom);
      s_e = 2'b11;
      @(negedge clk);
      if (i > 0) begin
        chk("stream_o_v", 32'(o_v), 32'h1);
        chk("stream_o_s", 32'(o_s), 32'((i - 1) % 2));
        chk("stream_lk", 32'(lk), 32'h3);
      end
    end
    @(posedge clk); #1 s_v = 2'b00;
    @(negedge clk);
    chk("stream_last_o_s", 32'(o_s), 32'h1);
    @(posedge clk);

    // Backpressure fills the skid, then drains in order.
    #1 s_v = 2'b10; s_d = {8'h11, 8'h00}; o_r = 1'b1;
    @(posedge clk); #1 o_r = 1'b0; s_d = {8'h22, 8'h00};
    @(posedge clk); #1 s_d = {8'h33, 8'h00};
    @(negedge clk);
    chk("bp_s_r", 32'(s_r), 32'h0);
    chk("bp_o_d_hold", 32'(o_d), 32'h11);
    @(posedge clk); #1 s_v = 2'b00; o_r = 1'b1;
    @(negedge clk);
    chk("bp_o_d_stable", 32'(o_d), 32'h11);
    @(negedge clk);
    chk("bp_o_d_second", 32'(o_d), 32'h22);
    chk("bp_s_r_back", 32'(s_r), 32'h1);
    @(negedge clk);
    chk("bp_drained", 32'(o_v), 32'h0);

    // Three-beat packet on way 1.
    @(posedge clk); #1 s_v = 2'b01; s_e = 2'b00; s_d = {8'h00, 8'hB1};
    @(posedge clk); #1 s_d = {8'h00, 8'hB2};
    @(negedge clk);
    chk("pkt_lk_1", 32'(lk), 32'h1);
    chk("pkt_o_e_1", 32'(o_e), 32'h0);
    @(posedge clk); #1 s_d = {8'h00, 8'hB3}; s_e = 2'b01;
    @(negedge clk);
    chk("pkt_lk_2", 32'(lk), 32'h1);
    @(posedge clk); #1 s_v = 2'b00;
    @(negedge clk);
    chk("pkt_lk_free", 32'(lk), 32'h3);
    chk("pkt_o_e_3", 32'(o_e), 32'h1);
    chk("pkt_o_d_3", 32'(o_d), 32'hB3);

    // Multi-bit grant: way 0 wins, error raised.
    @(posedge clk); #1 s_v = 2'b11; s_e = 2'b11; s_d = {8'h77, 8'h88};
    @(posedge clk); #1 s_v = 2'b00;
    @(negedge clk);
    chk("multi_err", 32'(err), 32'h1);
    chk("multi_o_s", 32'(o_s), 32'h0);
    chk("multi_o_d", 32'(o_d), 32'h77);

    // Lock violation after a clean reset.
    pulse_reset();
    @(posedge clk);
    @(posedge clk); #1 s_v = 2'b01; s_e = 2'b00; s_d = {8'h00, 8'h44};
    @(posedge clk); #1 s_v = 2'b10; s_e = 2'b11; s_d = {8'h99, 8'h00};
    @(negedge clk);
    chk("viol_err_before", 32'(err), 32'h0);
    chk("viol_lk_before", 32'(lk), 32'h1);
    @(posedge clk); #1 s_v = 2'b00;
    @(negedge clk);
    chk("viol_err", 32'(err), 32'h1);
    chk("viol_o_d", 32'(o_d), 32'h99);
    chk("viol_lk_kept", 32'(lk), 32'h1);

    // Async reset mid-packet with both entries full.
    @(posedge clk); #1 o_r = 1'b0; s_v = 2'b01; s_e = 2'b00; s_d = {8'h00, 8'h55};
    @(posedge clk);
    @(posedge clk); #1;
    chk("full_s_r", 32'(s_r), 32'h0);
    chk("full_o_v", 32'(o_v), 32'h1);
    #1 reset_n = 1'b0;
    #1;
    chk("arst_o_v", 32'(o_v), 32'h0);
    chk("arst_o_d", 32'(o_d), 32'h0);
    chk("arst_o_e", 32'(o_e), 32'h0);
    chk("arst_o_s", 32'(o_s), 32'h0);
    chk("arst_err", 32'(err), 32'h0);
    chk("arst_lk", 32'(lk), 32'h3);
    chk("arst_s_r", 32'(s_r), 32'h0);
    @(posedge clk); #2 reset_n = 1'b1; s_v = 2'b00; o_r = 1'b1;
    @(negedge clk);
    chk("post_rst_lk", 32'(lk), 32'h3);
    chk("post_rst_err", 32'(err), 32'h0);

    // Randomized traffic in segments, each starting from a reset.
    for (int seg = 0; seg < 4; seg++) begin
      pulse_reset();
      for (int cyc = 0; cyc < 750; cyc++) begin
        @(posedge clk); #1;
        o_r = ($urandom_range(3) != 0);
        s_d = 16'($urandom);
        s_e = {($urandom_range(2) == 0), ($urandom_range(2) == 0)};
        r = $urandom_range(99);
        if (r < 2 - (seg % 2)) begin
          s_v = 2'b11;
        end else if (r < 70) begin
          if (m_lock >= 0) way = (r < 4) ? 1 - m_lock : m_lock;
          else             way = $urandom_range(1);
          s_v = 2'(1 << (W - 1 - way));
        end else begin
          s_v = 2'b00;
        end
      end
    end

    @(posedge clk); #1 s_v = 2'b00; o_r = 1'b1;
    repeat (4) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
